// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions
// and the fetch-unit state encoding.
package cpu_pkg;

   localparam logic [3:0] OP_MOV  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_NOT  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_LT   = 4'b1010;
   localparam logic [3:0] OP_EQ   = 4'b1011;
   localparam logic [3:0] OP_MVI  = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam int unsigned OPC_HI = 15;
   localparam int unsigned OPC_LO = 12;
   localparam int unsigned DST_HI = 11;
   localparam int unsigned DST_LO = 6;
   localparam int unsigned SRC_HI = 5;
   localparam int unsigned SRC_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ISSUE,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM read port plus the instruction handshake towards the CU.
interface instr_fetch_if #(
   parameter int unsigned PC_W = 8
);
   logic [PC_W-1:0] rom_address;
   logic            rom_read_enable;
   logic [15:0]     rom_data;
   logic [3:0]      opcode;
   logic [5:0]      dest;
   logic [5:0]      src;
   logic            instr_valid;
   logic            instr_ready;
   logic            jump_en;
   logic [PC_W-1:0] jump_addr;

   modport master (
      output rom_address, rom_read_enable, opcode, dest, src, instr_valid,
      input  rom_data, instr_ready, jump_en, jump_addr
   );

   modport slave (
      input  rom_address, rom_read_enable, opcode, dest, src, instr_valid,
      output rom_data, instr_ready, jump_en, jump_addr
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one ROM word per instruction, holds it until
// the CU accepts it, then advances or redirects the pc; HALT_OP stops fetching.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter logic [3:0]  HALT_OP = OP_HALT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   instr_fetch_if.master   bus,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            busy
);

   fetch_state_t    state, state_n;
   logic [PC_W-1:0] pc_n;
   logic [15:0]     instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= '0;
         instr <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         // ROM word is valid the cycle after the strobe, i.e. while in WAIT
         if (state == S_WAIT) instr <= bus.rom_data;
      end
   end

   always_comb begin
      state_n             = state;
      pc_n                = pc;
      bus.rom_read_enable = 1'b0;
      bus.instr_valid     = 1'b0;
      halted              = 1'b0;
      busy                = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_n = S_REQ;
         end
         S_REQ: begin
            bus.rom_read_enable = 1'b1;
            state_n             = S_WAIT;
         end
         S_WAIT: state_n = S_ISSUE;
         S_ISSUE: begin
            bus.instr_valid = 1'b1;
            if (bus.instr_ready) begin
               if (instr[OPC_HI:OPC_LO] == HALT_OP) begin
                  state_n = S_HALT;
               end else begin
                  state_n = S_REQ;
                  pc_n    = bus.jump_en ? bus.jump_addr : pc + 1'b1;
               end
            end
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.rom_address = pc;
   assign bus.opcode      = instr[OPC_HI:OPC_LO];
   assign bus.dest        = instr[DST_HI:DST_LO];
   assign bus.src         = instr[SRC_HI:SRC_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, directed corner cases and a randomized
// run against a transaction-level fetch model.
module tb_instr_fetch;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] pc;
   logic       halted;
   logic       busy;

   always #5 clk = ~clk;

   instr_fetch_if #(.PC_W(8)) bus ();

   instr_fetch #(.PC_W(8), .HALT_OP(OP_HALT)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus.master),
      .pc     (pc),
      .halted (halted),
      .busy   (busy)
   );

   logic [15:0] rom [256];
   int          reads = 0;

   always @(posedge clk) begin
      if (bus.rom_read_enable) begin
         bus.rom_data <= rom[bus.rom_address];
         reads        <= reads + 1;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      start           = 1'b0;
      bus.instr_ready = 1'b0;
      bus.jump_en     = 1'b0;
      bus.jump_addr   = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (bus.instr_valid !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      chk("valid_seen", bus.instr_valid, 1);
   endtask

   typedef struct {
      logic [7:0]  at;
      logic [15:0] word;
      int          hold;
      logic        jen;
      logic [7:0]  jaddr;
      logic        is_halt;
      logic [3:0]  e_op;
      logic [5:0]  e_dst;
      logic [5:0]  e_src;
      logic [7:0]  e_next;
   } vec_t;

   vec_t vt[5];

   // transaction-level model state for the random run
   logic        m_run, m_halt;
   logic [7:0]  m_pc;
   int          m_cd;
   logic [15:0] w;

   initial begin
      int n;
      int r0;

      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

      vt[0] = '{8'h10, 16'h1042, 0, 1'b0, 8'h00, 1'b0, 4'h1, 6'h01, 6'h02, 8'h11};
      vt[1] = '{8'hFF, 16'h2FFF, 1, 1'b0, 8'h00, 1'b0, 4'h2, 6'h3F, 6'h3F, 8'h00};
      vt[2] = '{8'h20, 16'hC5A5, 5, 1'b1, 8'h40, 1'b0, 4'hC, 6'h16, 6'h25, 8'h40};
      vt[3] = '{8'h30, 16'hF000, 0, 1'b1, 8'h55, 1'b1, 4'hF, 6'h00, 6'h00, 8'h30};
      vt[4] = '{8'h7F, 16'h9ABC, 2, 1'b0, 8'h00, 1'b0, 4'h9, 6'h2A, 6'h3C, 8'h80};

      // reset state, then ROM[0]=1042 / ROM[1]=F000 program
      do_reset();
      chk("rst_pc", pc, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_rre", bus.rom_read_enable, 0);
      chk("rst_halted", halted, 0);
      chk("rst_busy", busy, 0);
      chk("rst_opcode", bus.opcode, 0);
      rom[0] = 16'h1042;
      rom[1] = 16'hF000;
      bus.instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("req_rre", bus.rom_read_enable, 1);
      chk("req_addr", bus.rom_address, 0);
      wait_valid(10, n);
      chk("start_latency", n + 1, 3);
      chk("p0_opcode", bus.opcode, 1);
      chk("p0_dest", bus.dest, 1);
      chk("p0_src", bus.src, 2);
      step();
      wait_valid(10, n);
      chk("issue_gap", n + 1, 3);
      chk("p1_opcode", bus.opcode, 4'hF);
      chk("p1_pc", pc, 1);
      step();
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, 1);
      chk("halt_busy", busy, 0);
      chk("halt_valid", bus.instr_valid, 0);

      // everything toggled while halted
      r0 = reads;
      for (int i = 0; i < 10; i++) begin
         start           = 1'($urandom_range(0, 1));
         bus.jump_en     = 1'($urandom_range(0, 1));
         bus.jump_addr   = 8'($urandom);
         bus.instr_ready = 1'($urandom_range(0, 1));
         step();
         chk("halt_stays", halted, 1);
         chk("halt_no_rre", bus.rom_read_enable, 0);
      end
      chk("halt_no_reads", reads - r0, 0);
      do_reset();
      chk("halt_cleared", halted, 0);

      // vector table: jump to the vector address, issue, hold, release
      for (int v = 0; v < 5; v++) begin
         do_reset();
         rom[0]        = 16'h1000;
         rom[vt[v].at] = vt[v].word;
         start = 1'b1;
         step();
         start = 1'b0;
         wait_valid(10, n);
         bus.instr_ready = 1'b1;
         bus.jump_en     = 1'b1;
         bus.jump_addr   = vt[v].at;
         step();
         bus.instr_ready = 1'b0;
         bus.jump_en     = 1'b0;
         chk("v_jump_addr", bus.rom_address, vt[v].at);
         wait_valid(10, n);
         chk("v_opcode", bus.opcode, vt[v].e_op);
         chk("v_dest", bus.dest, vt[v].e_dst);
         chk("v_src", bus.src, vt[v].e_src);
         for (int h = 0; h < vt[v].hold; h++) begin
            step();
            chk("hold_valid", bus.instr_valid, 1);
            chk("hold_opcode", bus.opcode, vt[v].e_op);
            chk("hold_dest", bus.dest, vt[v].e_dst);
            chk("hold_src", bus.src, vt[v].e_src);
            chk("hold_pc", pc, vt[v].at);
            chk("hold_rre", bus.rom_read_enable, 0);
         end
         bus.instr_ready = 1'b1;
         bus.jump_en     = vt[v].jen;
         bus.jump_addr   = vt[v].jaddr;
         step();
         bus.instr_ready = 1'b0;
         bus.jump_en     = 1'b0;
         if (vt[v].is_halt) begin
            chk("v_halted", halted, 1);
            chk("v_halt_pc", pc, vt[v].e_next);
            for (int h = 0; h < 3; h++) begin
               step();
               chk("v_halt_rre", bus.rom_read_enable, 0);
            end
         end else begin
            chk("v_next_rre", bus.rom_read_enable, 1);
            chk("v_next_addr", bus.rom_address, vt[v].e_next);
         end
      end

      // jump_en outside a transfer has no effect
      do_reset();
      rom[0] = 16'h2000;
      start = 1'b1;
      step();
      start = 1'b0;
      bus.jump_en   = 1'b1;
      bus.jump_addr = 8'h40;
      step();
      step();
      bus.jump_en     = 1'b0;
      bus.instr_ready = 1'b1;
      chk("nj_valid", bus.instr_valid, 1);
      step();
      bus.instr_ready = 1'b0;
      chk("nj_addr", bus.rom_address, 1);
      chk("nj_rre", bus.rom_read_enable, 1);

      // reset mid-handshake discards the instruction
      do_reset();
      rom[0] = 16'h3123;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid(10, n);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_valid", bus.instr_valid, 0);
      chk("mr_opcode", bus.opcode, 0);
      chk("mr_dest", bus.dest, 0);
      chk("mr_src", bus.src, 0);
      chk("mr_pc", pc, 0);
      chk("mr_rre", bus.rom_read_enable, 0);
      chk("mr_busy", busy, 0);
      chk("mr_halted", halted, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mr_idle_rre", bus.rom_read_enable, 0);
         chk("mr_idle_busy", busy, 0);
      end

      // randomized run against the transaction model
      for (int i = 0; i < 256; i++) begin
         rom[i] = 16'($urandom);
         if (rom[i][15:12] == OP_HALT && $urandom_range(0, 3) != 0) rom[i][15:12] = OP_MOV;
      end
      do_reset();
      m_run  = 1'b0;
      m_halt = 1'b0;
      m_pc   = '0;
      m_cd   = 0;
      for (int c = 0; c < 3000; c++) begin
         rst             = ($urandom_range(0, 199) == 0) || (m_halt && $urandom_range(0, 15) == 0);
         start           = ($urandom_range(0, 3) == 0);
         bus.instr_ready = 1'($urandom_range(0, 1));
         bus.jump_en     = ($urandom_range(0, 3) == 0);
         bus.jump_addr   = 8'($urandom);
         if (rst) begin
            m_run = 1'b0; m_halt = 1'b0; m_pc = '0; m_cd = 0;
         end else if (!m_run && !m_halt) begin
            if (start) begin m_run = 1'b1; m_cd = 2; end
         end else if (m_run) begin
            if (m_cd > 0) begin
               m_cd--;
            end else if (bus.instr_ready) begin
               w = rom[m_pc];
               if (w[15:12] == OP_HALT) begin
                  m_run = 1'b0; m_halt = 1'b1;
               end else begin
                  m_pc = bus.jump_en ? bus.jump_addr : m_pc + 8'd1;
                  m_cd = 2;
               end
            end
         end
         step();
         chk("r_valid", bus.instr_valid, 32'(m_run && m_cd == 0));
         chk("r_rre", bus.rom_read_enable, 32'(m_run && m_cd == 2));
         chk("r_busy", busy, 32'(m_run));
         chk("r_halted", halted, 32'(m_halt));
         chk("r_pc", pc, m_pc);
         if (m_run && m_cd == 0) begin
            w = rom[m_pc];
            chk("r_instr", {bus.opcode, bus.dest, bus.src}, w);
         end
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, giving the program-counter and ROM address width.
REQ-002 The block SHALL have parameter HALT_OP, default 4'b1111, giving the opcode that stops fetching.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level; begins fetching from IDLE.
REQ-006 rom_address  output  PC_W  ROM read address, equal to pc.
REQ-007 rom_read_enable  output  1  ROM read strobe.
REQ-008 rom_data  input  16  ROM word, valid the cycle after the strobe.
REQ-009 opcode  output  4  instruction bits [15:12].
REQ-010 dest  output  6  instruction bits [11:6].
REQ-011 src  output  6  instruction bits [5:0].
REQ-012 instr_valid  output  1  opcode/dest/src hold an instruction for the CU.
REQ-013 instr_ready  input  1  CU accepts the instruction this cycle.
REQ-014 jump_en  input  1  redirect the next fetch.
REQ-015 jump_addr  input  PC_W  redirect target.
REQ-016 pc  output  PC_W  address of the current or next fetch.
REQ-017 halted  output  1  HALT_OP has been accepted.
REQ-018 busy  output  1  state is not IDLE and not HALT.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, ISSUE and HALT.
REQ-020 IDLE SHALL go to REQ on the clock edge where start=1; otherwise it stays in IDLE.
REQ-021 REQ SHALL drive rom_read_enable=1 and rom_address=pc for exactly one cycle, then go to WAIT.
REQ-022 WAIT SHALL register rom_data into opcode/dest/src, keep rom_read_enable=0, and go to ISSUE.
REQ-023 instr_valid SHALL be 1 only in ISSUE, rising 3 cycles after start is sampled in IDLE.
REQ-024 In ISSUE with instr_ready=0, opcode/dest/src/pc SHALL hold stable, and instr_valid SHALL stay 1.
REQ-025 A transfer SHALL occur in ISSUE when instr_valid=1 and instr_ready=1.
REQ-026 On a transfer with a non-HALT opcode, pc SHALL become pc+1 modulo 2^PC_W (255 wraps to 0 for PC_W=8), and the next state SHALL be REQ.
REQ-027 On a transfer with jump_en=1, pc SHALL become jump_addr, overriding the increment.
REQ-028 jump_en SHALL be ignored in every cycle that is not a transfer.
REQ-029 On a transfer with opcode==HALT_OP, the next state SHALL be HALT, pc SHALL be unchanged, halted SHALL become 1, and jump_en SHALL be ignored.
REQ-030 HALT SHALL ignore start, instr_ready and jump_en, and SHALL be left only by rst.
REQ-031 start SHALL be ignored outside IDLE.
REQ-032 Peak throughput SHALL be one instruction per 3 cycles.

Reset
REQ-033 While rst=1 at a clock edge, the state SHALL become IDLE, and pc, opcode, dest, src, instr_valid, rom_read_enable, halted and busy SHALL all become 0.
REQ-034 rst SHALL take priority over every other input in every state, including mid-handshake; an unaccepted instruction is discarded.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the opcode constants (MOV 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOT 0111, SHL 1000, SHR 1001, LT 1010, EQ 1011, MVI 1100, HALT 1111), the instruction field bit positions, and the fetch state encoding.
REQ-036 The block SHALL be a single module with no sub-module; it connects to the existing ROM and CU instances at the top level.

Verification
REQ-037 ROM[0]=16'h1042, ROM[1]=16'hF000, start pulse, ready=1 -> instr_valid at cycle+3 with opcode=1, dest=1, src=2; second issue has opcode=F; then halted=1 and pc=1.
REQ-038 instr_ready held 0 for 5 cycles in ISSUE -> outputs are stable and rom_read_enable=0 throughout; transfer happens on the first ready=1 cycle.
REQ-039 pc=255 with a non-HALT instruction accepted -> next rom_address=0.
REQ-040 jump_en=1, jump_addr=8'h40 on a transfer -> next rom_address=8'h40; jump_en pulsed in WAIT -> no effect.
REQ-041 rst asserted in ISSUE with instr_valid=1 -> next cycle all outputs are 0 and the FSM is in IDLE.
REQ-042 start and jump_en toggled while in HALT -> no ROM reads; halted stays 1 until rst.
